gobang_move_arbiter: RTL and testbench
======================================

# gobang_move_arbiter

Sequencer and arbiter for the board datapath's single write port. It accepts move requests from the keyboard-driven player path and the AI engine, checks the target cell for occupancy and range, and issues one-cycle write, clear or erase strobes to the datapath. It keeps a move-history stack for undo and last-move display, and runs in the slow game-clock domain alongside the game logic and datapath.

## Interface

- HIST_DEPTH, 225: history stack entries (15×15 board).
- CNT_W, 8: width of move counter and stack pointer.

- clk  in  1  game clock (slow divided clock).
- rst  in  1  asynchronous reset, active-low (0 = reset).
- new_game  in  1  single-cycle pulse requesting a board clear.
- p_req  in  1  player move request; level, held until p_grant or reject.
- p_i, p_j  in  4 each  player target row/column.
- a_req  in  1  AI move request; level, held until a_grant or reject.
- a_i, a_j  in  4 each  AI target row/column.
- undo_req  in  1  undo request; level, held until undo_done or reject.
- crt_color  in  1  side to move (1 = black); sampled at grant decision.
- cell_occupied  in  1  datapath occupancy of (look_i, look_j); combinational, same cycle.
- look_i, look_j  out  4 each  cell address for the occupancy check.
- data_clr  out  1  datapath clear strobe.
- data_write  out  1  datapath write strobe.
- data_erase  out  1  datapath erase strobe.
- write_i, write_j  out  4 each  address for write or erase.
- write_color  out  1  colour for write.
- p_grant, a_grant  out  1 each  move accepted and written.
- reject  out  1  request refused.
- undo_done  out  1  undo completed.
- busy  out  1  FSM not in IDLE.
- move_count  out  CNT_W  stones on the board.
- last_valid  out  1  move_count ≠ 0.
- last_i, last_j  out  4 each  top-of-stack move; 0 when empty.

## Operation

- Moore FSM. States: IDLE, CHECK, WRITE, CLEAR, UNDO. All strobes are decoded from the state and latched registers.
- IDLE priority:
  - pending_clr (set by a new_game pulse in any state, cleared on entering CLEAR) goes to CLEAR;
  - otherwise undo_req goes to UNDO;
  - otherwise p_req or a_req goes to CHECK.
- Arbitration between simultaneous p_req and a_req is round-robin on a last_served bit. Reset value is AI, so the player wins the first tie. With only one requester, that requester wins. The winner's i, j and id, plus crt_color, are latched on the transition to CHECK.
- CHECK: look_i/look_j drive the latched coordinates.
  - reject=1 for one cycle, then IDLE, if cell_occupied=1, or i>14, or j>14, or move_count==HIST_DEPTH.
  - Otherwise go to WRITE.
- WRITE (one cycle):
  - Drives data_write=1, write_i/write_j/write_color from the latches, and the winner's grant=1.
  - Pushes {i,j} onto the stack, increments move_count, updates last_served, then returns to IDLE.
- CLEAR (one cycle): data_clr=1. move_count←0. Stack contents are not scrubbed. Returns to IDLE.
- UNDO (one cycle):
  - move_count==0: reject=1, no erase.
  - Otherwise: data_erase=1 with write_i/write_j = top entry, undo_done=1, move_count decrements.
  - Returns to IDLE.
- last_i/last_j always show stack[move_count-1].
- Requesters must drop their request on the clock edge where grant, undo_done or reject is high. The FSM never re-samples a request in the cycle it acknowledges it.
- Inactive outputs are 0: write_i, write_j and write_color are 0 outside WRITE/UNDO, and look_i/look_j are 0 outside CHECK.

## Timing

- Reset (rst=0, asynchronous): state=IDLE, pending_clr=0, move_count=0, last_served=AI. All outputs are 0. Stack RAM is not reset. Reset mid-operation aborts without a strobe.
- Move latency: request seen in IDLE at cycle N → CHECK at N+1 (reject here if illegal) → WRITE with grant at N+2 → IDLE at N+3. The back-to-back move rate is one per 3 cycles.
- Undo and clear: seen at N → strobe at N+1 → IDLE at N+2.
- A new_game pulse arriving during CHECK, WRITE or UNDO completes that operation first, then CLEAR follows on the next IDLE.
- Every strobe is exactly one cycle long. At most one of data_write, data_clr and data_erase is high in any cycle.
- move_count saturates by construction: there is no increment at HIST_DEPTH and no decrement at 0.

## Test plan

- Reset and single move:
  - Stimulus: release rst, then p_req with (7,7) and crt_color=1.
  - Required: data_write high exactly at cycle N+2 with write (7,7,1); p_grant high in the same cycle; move_count=1; last_i/last_j=(7,7).
- Tie arbitration:
  - Stimulus: p_req (3,4) and a_req (5,6) both held.
  - Required: player granted first, at N+2. AI (5,6) granted at N+5. move_count=2.
- Occupied or out-of-range:
  - Stimulus: write (7,7), then p_req (7,7) with cell_occupied=1; then p_req (15,0).
  - Required: reject at N+1 in each case, no data_write, move_count unchanged.
- Undo:
  - Stimulus: after moves (1,1) then (2,2), assert undo_req.
  - Required: data_erase with write (2,2) and undo_done at N+1; move_count=1; last_i/last_j=(1,1).
  - Stimulus: two further undos.
  - Required: the second of them gives reject with no erase.
- Clear priority and mid-operation:
  - Stimulus: new_game pulse during CHECK of a legal move.
  - Required: the move's WRITE completes, then data_clr on the next cycle after IDLE; move_count=0; last_valid=0.
- Asynchronous reset:
  - Stimulus: assert rst low during WRITE.
  - Required: all outputs drop to 0 immediately; after release, the FSM is in IDLE with move_count=0.

Source files
------------

// File: rtl/gobang_move_arbiter.sv
// Single-write-port sequencer for the gobang board datapath: arbitrates player/AI
// moves, validates the target cell, and keeps a move-history stack for undo.
`timescale 1ns/1ps
module gobang_move_arbiter #(
  parameter int HIST_DEPTH = 225,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             p_req,
  input  logic [3:0]       p_i,
  input  logic [3:0]       p_j,
  input  logic             a_req,
  input  logic [3:0]       a_i,
  input  logic [3:0]       a_j,
  input  logic             undo_req,
  input  logic             crt_color,
  input  logic             cell_occupied,
  output logic [3:0]       look_i,
  output logic [3:0]       look_j,
  output logic             data_clr,
  output logic             data_write,
  output logic             data_erase,
  output logic [3:0]       write_i,
  output logic [3:0]       write_j,
  output logic             write_color,
  output logic             p_grant,
  output logic             a_grant,
  output logic             reject,
  output logic             undo_done,
  output logic             busy,
  output logic [CNT_W-1:0] move_count,
  output logic             last_valid,
  output logic [3:0]       last_i,
  output logic [3:0]       last_j
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, CLEAR, UNDO} state_e;
  localparam logic ID_PLAYER = 1'b0;
  localparam logic ID_AI     = 1'b1;

  state_e           state, state_nxt;
  logic             pending_clr;
  logic             last_served;
  logic [3:0]       lat_i, lat_j;
  logic             lat_id, lat_color;
  logic [7:0]       stack [HIST_DEPTH];
  logic             stack_empty;
  logic [3:0]       top_i, top_j;
  logic             illegal;
  logic             pick_ai;

  assign stack_empty = (move_count == '0);
  assign {top_i, top_j} = stack_empty ? 8'h00 : stack[move_count - 1'b1];
  assign last_valid  = ~stack_empty;
  assign last_i      = top_i;
  assign last_j      = top_j;
  assign busy        = (state != IDLE);

  // Round-robin: on a tie, the side not served last wins.
  assign pick_ai = a_req & (~p_req | (last_served == ID_PLAYER));
  assign illegal = cell_occupied | (lat_i > 4'd14) | (lat_j > 4'd14) |
                   (move_count == CNT_W'(HIST_DEPTH));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt   = state;
    look_i      = '0;
    look_j      = '0;
    data_clr    = 1'b0;
    data_write  = 1'b0;
    data_erase  = 1'b0;
    write_i     = '0;
    write_j     = '0;
    write_color = 1'b0;
    p_grant     = 1'b0;
    a_grant     = 1'b0;
    reject      = 1'b0;
    undo_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending_clr)         state_nxt = CLEAR;
        else if (undo_req)       state_nxt = UNDO;
        else if (p_req || a_req) state_nxt = CHECK;
      end
      CHECK: begin
        look_i    = lat_i;
        look_j    = lat_j;
        reject    = illegal;
        state_nxt = illegal ? IDLE : WRITE;
      end
      WRITE: begin
        data_write  = 1'b1;
        write_i     = lat_i;
        write_j     = lat_j;
        write_color = lat_color;
        p_grant     = (lat_id == ID_PLAYER);
        a_grant     = (lat_id == ID_AI);
        state_nxt   = IDLE;
      end
      CLEAR: begin
        data_clr  = 1'b1;
        state_nxt = IDLE;
      end
      UNDO: begin
        if (stack_empty) begin
          reject = 1'b1;
        end else begin
          data_erase = 1'b1;
          write_i    = top_i;
          write_j    = top_j;
          undo_done  = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending_clr <= 1'b0;
      last_served <= ID_AI;
      move_count  <= '0;
      lat_i       <= '0;
      lat_j       <= '0;
      lat_id      <= ID_PLAYER;
      lat_color   <= 1'b0;
    end else begin
      state <= state_nxt;
      // A pulse landing on the same edge as entering CLEAR is kept for another clear.
      if (new_game)
        pending_clr <= 1'b1;
      else if (state == IDLE && state_nxt == CLEAR)
        pending_clr <= 1'b0;
      if (state == IDLE && state_nxt == CHECK) begin
        lat_i     <= pick_ai ? a_i : p_i;
        lat_j     <= pick_ai ? a_j : p_j;
        lat_id    <= pick_ai ? ID_AI : ID_PLAYER;
        lat_color <= crt_color;
      end
      unique case (state)
        WRITE: begin
          move_count  <= move_count + 1'b1;
          last_served <= lat_id;
        end
        CLEAR: move_count <= '0;
        UNDO:  if (!stack_empty) move_count <= move_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the history RAM has no reset; move_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (state == WRITE)
      stack[move_count] <= {lat_i, lat_j};
  end

endmodule

// File: tb/tb_gobang_move_arbiter.sv
// Bench for gobang_move_arbiter: a transaction-level game model checked every cycle,
// plus directed scenarios with hand-computed latencies and values.
`timescale 1ns/1ps
module tb_gobang_move_arbiter;
  localparam int HIST_DEPTH = 225;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic new_game = 1'b0, p_req = 1'b0, a_req = 1'b0, undo_req = 1'b0, crt_color = 1'b0;
  logic [3:0] p_i = '0, p_j = '0, a_i = '0, a_j = '0;
  logic cell_occupied;
  logic [3:0] look_i, look_j, write_i, write_j, last_i, last_j;
  logic data_clr, data_write, data_erase, write_color, p_grant, a_grant;
  logic reject, undo_done, busy, last_valid;
  logic [CNT_W-1:0] move_count;

  int n_cmp = 0;
  int n_fail = 0;

  gobang_move_arbiter #(.HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .p_req(p_req), .p_i(p_i), .p_j(p_j),
    .a_req(a_req), .a_i(a_i), .a_j(a_j),
    .undo_req(undo_req), .crt_color(crt_color), .cell_occupied(cell_occupied),
    .look_i(look_i), .look_j(look_j),
    .data_clr(data_clr), .data_write(data_write), .data_erase(data_erase),
    .write_i(write_i), .write_j(write_j), .write_color(write_color),
    .p_grant(p_grant), .a_grant(a_grant), .reject(reject), .undo_done(undo_done),
    .busy(busy), .move_count(move_count), .last_valid(last_valid),
    .last_i(last_i), .last_j(last_j)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  // The board the datapath would hold, and the list of stones in play order.
  bit board [15][15];
  bit [7:0] hist [$];
  typedef enum {M_IDLE, M_CHECK, M_WRITE, M_CLEAR, M_UNDO} mphase_e;
  mphase_e m_ph = M_IDLE;
  bit [3:0] m_i = '0, m_j = '0;
  bit m_ai = 1'b0, m_color = 1'b0, m_pend = 1'b0, m_last_ai = 1'b1;

  assign cell_occupied = (look_i < 4'd15 && look_j < 4'd15) ? board[look_i][look_j] : 1'b0;

  function automatic bit m_illegal();
    return (m_i > 4'd14) || (m_j > 4'd14) || (hist.size() == HIST_DEPTH) || board[m_i][m_j];
  endfunction

  function automatic logic [41:0] model_out();
    logic [3:0] li = '0, lj = '0, wi = '0, wj = '0, ti = '0, tj = '0;
    logic clr = 0, wr = 0, er = 0, wc = 0, pg = 0, ag = 0, rj = 0, ud = 0, bz;
    if (hist.size() != 0) {ti, tj} = hist[$];
    bz = (m_ph != M_IDLE);
    case (m_ph)
      M_CHECK: begin li = m_i; lj = m_j; rj = m_illegal(); end
      M_WRITE: begin wr = 1; wi = m_i; wj = m_j; wc = m_color; pg = !m_ai; ag = m_ai; end
      M_CLEAR: clr = 1;
      M_UNDO:  if (hist.size() == 0) rj = 1;
               else begin er = 1; wi = ti; wj = tj; ud = 1; end
      default: ;
    endcase
    return {li, lj, clr, wr, er, wi, wj, wc, pg, ag, rj, ud, bz,
            8'(hist.size()), hist.size() != 0, ti, tj};
  endfunction

  always @(posedge clk or negedge rst) begin : model_step
    bit ill;
    bit [7:0] top;
    if (!rst) begin
      m_ph = M_IDLE; m_pend = 0; m_last_ai = 1; hist.delete();
      foreach (board[x, y]) board[x][y] = 0;
    end else begin
      ill = m_illegal();
      case (m_ph)
        M_IDLE: begin
          if (m_pend) begin m_ph = M_CLEAR; m_pend = 0; end
          else if (undo_req) m_ph = M_UNDO;
          else if (p_req || a_req) begin
            m_ai    = a_req && (!p_req || !m_last_ai);
            m_i     = m_ai ? a_i : p_i;
            m_j     = m_ai ? a_j : p_j;
            m_color = crt_color;
            m_ph    = M_CHECK;
          end
        end
        M_CHECK: m_ph = ill ? M_IDLE : M_WRITE;
        M_WRITE: begin
          hist.push_back({m_i, m_j});
          board[m_i][m_j] = 1;
          m_last_ai = m_ai;
          m_ph = M_IDLE;
        end
        M_CLEAR: begin
          hist.delete();
          foreach (board[x, y]) board[x][y] = 0;
          m_ph = M_IDLE;
        end
        M_UNDO: begin
          if (hist.size() != 0) begin
            top = hist.pop_back();
            board[top[7:4]][top[3:0]] = 0;
          end
          m_ph = M_IDLE;
        end
        default: m_ph = M_IDLE;
      endcase
      if (new_game) m_pend = 1;
    end
  end

  logic [41:0] dut_out;
  assign dut_out = {look_i, look_j, data_clr, data_write, data_erase, write_i, write_j,
                    write_color, p_grant, a_grant, reject, undo_done, busy,
                    move_count, last_valid, last_i, last_j};

  always @(negedge clk) if ($time > 20) check("cycle_outputs", dut_out, model_out());

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offset counts cycles from N, the first cycle the request is visible in IDLE.
  task automatic run_move(input bit ai, input logic [3:0] i, input logic [3:0] j,
                          input bit color, output int off, output bit ok,
                          output logic [9:0] wcap);
    if (ai) begin a_req = 1; a_i = i; a_j = j; end
    else    begin p_req = 1; p_i = i; p_j = j; end
    crt_color = color;
    off = -1; ok = 0; wcap = '0;
    for (int k = 0; k < 12 && off < 0; k++) begin
      @(negedge clk);
      if (ai ? a_grant : p_grant) begin
        off = k; ok = 1; wcap = {data_write, write_i, write_j, write_color};
      end else if (reject) off = k;
    end
    tick();
    p_req = 0; a_req = 0;
    if (off < 0) check("move_timeout", 0, 1);
  endtask

  task automatic run_undo(output int off, output bit ok, output logic [8:0] ecap);
    undo_req = 1; off = -1; ok = 0; ecap = '0;
    for (int k = 0; k < 12 && off < 0; k++) begin
      @(negedge clk);
      if (undo_done) begin off = k; ok = 1; ecap = {data_erase, write_i, write_j}; end
      else if (reject) off = k;
    end
    tick();
    undo_req = 0;
    if (off < 0) check("undo_timeout", 0, 1);
  endtask

  task automatic pulse_clear();
    bit seen = 0;
    new_game = 1; tick(); new_game = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (data_clr) seen = 1;
    end
    check("clear_seen", seen, 1);
    tick();
  endtask

  initial begin
    int off; bit ok; logic [9:0] wcap; logic [8:0] ecap;
    int pk, ak;

    #1 rst = 0;
    #2 check("reset_outputs", dut_out, 42'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    tick();

    // single move and reset state of counters
    run_move(0, 4'd7, 4'd7, 1, off, ok, wcap);
    check("t1_latency", off, 2);
    check("t1_write", wcap, {1'b1, 4'd7, 4'd7, 1'b1});
    @(negedge clk);
    check("t1_count", move_count, 1);
    check("t1_last", {last_valid, last_i, last_j}, {1'b1, 4'd7, 4'd7});
    tick();

    // lone AI request wins, leaving last_served = AI
    run_move(1, 4'd8, 4'd8, 0, off, ok, wcap);
    check("ai_single", {off[3:0], ok}, {4'd2, 1'b1});
    pulse_clear();
    @(negedge clk); check("clear_count", move_count, 0);
    tick();

    // tie: player first at N+2, AI at N+5
    p_req = 1; p_i = 4'd3; p_j = 4'd4; a_req = 1; a_i = 4'd5; a_j = 4'd6; crt_color = 0;
    pk = -1; ak = -1;
    for (int k = 0; k < 14 && (pk < 0 || ak < 0); k++) begin
      @(negedge clk);
      if (p_grant) pk = k;
      if (a_grant) ak = k;
      tick();
      if (pk == k) p_req = 0;
      if (ak == k) a_req = 0;
    end
    p_req = 0; a_req = 0;
    check("tie_player", pk, 2);
    check("tie_ai", ak, 5);
    @(negedge clk);
    check("tie_count", move_count, 2);
    check("tie_last", {last_i, last_j}, {4'd5, 4'd6});
    tick();

    // occupancy and range rejects
    run_move(0, 4'd7, 4'd7, 1, off, ok, wcap);
    check("occ_setup", ok, 1);
    run_move(0, 4'd7, 4'd7, 0, off, ok, wcap);
    check("occ_reject", {off[3:0], ok}, {4'd1, 1'b0});
    run_move(0, 4'd15, 4'd0, 0, off, ok, wcap);
    check("row_range_reject", {off[3:0], ok}, {4'd1, 1'b0});
    run_move(1, 4'd0, 4'd15, 0, off, ok, wcap);
    check("col_range_reject", {off[3:0], ok}, {4'd1, 1'b0});
    @(negedge clk); check("reject_count", move_count, 3);
    tick();

    // undo
    pulse_clear();
    run_move(0, 4'd1, 4'd1, 1, off, ok, wcap);
    run_move(1, 4'd2, 4'd2, 0, off, ok, wcap);
    run_undo(off, ok, ecap);
    check("undo1_latency", {off[3:0], ok}, {4'd1, 1'b1});
    check("undo1_erase", ecap, {1'b1, 4'd2, 4'd2});
    @(negedge clk);
    check("undo1_state", {move_count, last_i, last_j}, {8'd1, 4'd1, 4'd1});
    tick();
    run_undo(off, ok, ecap);
    check("undo2_ok", ok, 1);
    run_undo(off, ok, ecap);
    check("undo3_reject", {off[3:0], ok}, {4'd1, 1'b0});

    // new_game during CHECK: write completes, clear follows
    p_req = 1; p_i = 4'd4; p_j = 4'd4; crt_color = 1;
    tick();                          // N+1: CHECK
    new_game = 1;
    @(negedge clk); check("mid_check_look", {look_i, look_j, reject}, {4'd4, 4'd4, 1'b0});
    tick(); new_game = 0;            // N+2: WRITE
    @(negedge clk); check("mid_write", {p_grant, data_write, data_clr}, 3'b110);
    tick(); p_req = 0;               // N+3: IDLE
    @(negedge clk); check("mid_idle", {busy, move_count}, {1'b0, 8'd1});
    tick();                          // N+4: CLEAR
    @(negedge clk); check("mid_clear", {data_clr, data_write}, 2'b10);
    tick();
    @(negedge clk); check("mid_after", {move_count, last_valid}, 9'd0);
    tick();

    // asynchronous reset during WRITE
    p_req = 1; p_i = 4'd6; p_j = 4'd6; crt_color = 0;
    tick(); tick();
    @(negedge clk); check("rst_in_write", data_write, 1);
    #2 rst = 0;
    #1 check("rst_async_zero", dut_out, 42'd0);
    p_req = 0;
    tick(); tick();
    rst = 1;
    @(negedge clk); check("rst_released", {busy, move_count}, 9'd0);
    tick();
    run_move(0, 4'd9, 4'd9, 1, off, ok, wcap);
    check("post_rst_move", {off[3:0], ok}, {4'd2, 1'b1});
    @(negedge clk); check("post_rst_count", move_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
